ps2_mouse_seq: RTL

Host-side sequencer for the PS/2 mouse port: owns the open-drain `msclk`/`msdat` pair and runs the power-up command script. The script is reset, set sample rate 200, enable reporting. Each device acknowledge is checked, and the whole script is retried on error or timeout. After init the block switches to stream mode and delivers aligned 3-byte movement packets to the downstream accumulator/register logic.

---
 rtl/ps2_mouse_seq.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_seq.sv
`default_nettype none
// ============================================================================
// Module : ps2_mouse_seq
// Desc   : PS/2 mouse host sequencer: runs the power-up command script over
//          the open-drain clock/data pair, then streams 3-byte packets.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_mouse_seq #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  inout  wire         msclk,
  inout  wire         msdat,
  output logic        run,
  output logic        pkt_valid,
  output logic [23:0] pkt,
  output logic        err
);

  localparam int c_INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int c_TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int c_RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYC - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_INHIBIT = 3'd0,
    S_TX      = 3'd1,
    S_TXACK   = 3'd2,
    S_RX      = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5,
    S_DEAD    = 3'd6
  } state_t;

  state_t               r_state;
  logic                 r_clk_low;
  logic                 r_dat_low;
  logic                 r_clk_q0;
  logic                 r_clk_q1;
  logic                 r_dat_q0;
  logic [c_INH_W-1:0]   r_inh_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic [3:0]           r_bit_cnt;
  logic [8:0]           r_tx_sr;
  logic [9:0]           r_rx_sr;
  logic [1:0]           r_entry;
  logic [1:0]           r_reply;
  logic [c_RTY_W-1:0]   r_retry;
  logic [1:0]           r_slot;
  logic [7:0]           r_b0;
  logic [7:0]           r_b1;
  logic                 r_run;
  logic                 r_pkt_valid;
  logic [23:0]          r_pkt;
  logic                 r_err;

  logic                 w_fall;
  logic                 w_dat;
  logic [7:0]           w_byte;
  logic                 w_frame_ok;
  logic                 w_frame_end;
  logic [7:0]           w_cmd;
  logic [7:0]           w_exp;
  logic                 w_last_reply;
  logic                 w_to_active;
  logic                 w_to_expire;

  assign msclk = r_clk_low ? 1'b0 : 1'bz;
  assign msdat = r_dat_low ? 1'b0 : 1'bz;

  assign run       = r_run;
  assign pkt_valid = r_pkt_valid;
  assign pkt       = r_pkt;
  assign err       = r_err;

  assign w_fall = r_clk_q1 & ~r_clk_q0;
  assign w_dat  = r_dat_q0;

  // Shift register holds {parity, data[7:0], start}; the stop bit is the live sample.
  assign w_byte      = r_rx_sr[8:1];
  assign w_frame_ok  = ~r_rx_sr[0] & (^r_rx_sr[9:1]) & w_dat;
  assign w_frame_end = w_fall && (r_bit_cnt == 4'd10);

  assign w_to_active = (r_state == S_TX) || (r_state == S_TXACK) || (r_state == S_RX) ||
                       ((r_state == S_RUN) && (r_slot != 2'd0));
  assign w_to_expire = w_to_active && !w_fall && (r_to_cnt == c_TO_LAST);

  always_comb begin
    w_cmd        = 8'hFF;
    w_exp        = 8'hFA;
    w_last_reply = 1'b1;
    case (r_entry)
      2'd0:    w_cmd = 8'hFF;
      2'd1:    w_cmd = 8'hF3;
      2'd2:    w_cmd = 8'hC8;
      default: w_cmd = 8'hF4;
    endcase
    if (r_entry == 2'd0) begin
      w_last_reply = (r_reply == 2'd2);
      case (r_reply)
        2'd0:    w_exp = 8'hFA;
        2'd1:    w_exp = 8'hAA;
        default: w_exp = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_pkt_valid <= 1'b0;
    if (rst || restart) begin
      r_state   <= S_INHIBIT;
      r_clk_low <= 1'b1;
      r_dat_low <= 1'b0;
      r_clk_q0  <= 1'b1;
      r_clk_q1  <= 1'b1;
      r_dat_q0  <= 1'b1;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= 4'd0;
      r_tx_sr   <= 9'd0;
      r_rx_sr   <= 10'd0;
      r_entry   <= 2'd0;
      r_reply   <= 2'd0;
      r_retry   <= '0;
      r_slot    <= 2'd0;
      r_run     <= 1'b0;
      r_err     <= 1'b0;
      // A restart leaves the last delivered packet visible.
      if (rst) begin
        r_pkt <= 24'd0;
        r_b0  <= 8'd0;
        r_b1  <= 8'd0;
      end
    end else if (enable) begin
      r_clk_q0 <= msclk;
      r_clk_q1 <= r_clk_q0;
      r_dat_q0 <= msdat;

      if (!w_to_active || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        S_INHIBIT: begin
          if (r_inh_cnt == c_INH_LAST) begin
            r_inh_cnt <= '0;
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b1;
            r_tx_sr   <= {~^w_cmd, w_cmd};
            r_bit_cnt <= 4'd0;
            r_state   <= S_TX;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end

        S_TX: begin
          if (w_fall) begin
            if (r_bit_cnt == 4'd9) begin
              r_dat_low <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_TXACK;
            end else begin
              r_dat_low <= ~r_tx_sr[0];
              r_tx_sr   <= {1'b0, r_tx_sr[8:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (w_to_expire) begin
            r_state <= S_FAIL;
          end
        end

        S_TXACK: begin
          if (w_fall) begin
            r_bit_cnt <= 4'd0;
            r_reply   <= 2'd0;
            r_state   <= w_dat ? S_FAIL : S_RX;
          end else if (w_to_expire) begin
            r_state <= S_FAIL;
          end
        end

        S_RX: begin
          if (w_frame_end) begin
            r_bit_cnt <= 4'd0;
            if (w_frame_ok && (w_byte == w_exp)) begin
              if (!w_last_reply) begin
                r_reply <= r_reply + 2'd1;
              end else if (r_entry == 2'd3) begin
                r_run   <= 1'b1;
                r_slot  <= 2'd0;
                r_state <= S_RUN;
              end else begin
                r_entry   <= r_entry + 2'd1;
                r_reply   <= 2'd0;
                r_clk_low <= 1'b1;
                r_state   <= S_INHIBIT;
              end
            end else begin
              r_state <= S_FAIL;
            end
          end else if (w_fall) begin
            r_rx_sr   <= {w_dat, r_rx_sr[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_to_expire) begin
            r_state <= S_FAIL;
          end
        end

        S_RUN: begin
          if (w_frame_end) begin
            r_bit_cnt <= 4'd0;
            if (!w_frame_ok) begin
              r_slot <= 2'd0;
            end else begin
              case (r_slot)
                2'd0: begin
                  // Device self-test after hot-plug: re-run init with a fresh retry budget.
                  if (w_byte == 8'hAA) begin
                    r_retry <= '0;
                    r_state <= S_FAIL;
                  end else if (w_byte[3]) begin
                    r_b0   <= w_byte;
                    r_slot <= 2'd1;
                  end
                end
                2'd1: begin
                  r_b1   <= w_byte;
                  r_slot <= 2'd2;
                end
                default: begin
                  r_pkt       <= {w_byte, r_b1, r_b0};
                  r_pkt_valid <= 1'b1;
                  r_slot      <= 2'd0;
                end
              endcase
            end
          end else if (w_fall) begin
            r_rx_sr   <= {w_dat, r_rx_sr[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (w_to_expire) begin
            r_slot    <= 2'd0;
            r_bit_cnt <= 4'd0;
          end
        end

        S_FAIL: begin
          r_run     <= 1'b0;
          r_dat_low <= 1'b0;
          r_slot    <= 2'd0;
          r_bit_cnt <= 4'd0;
          r_entry   <= 2'd0;
          r_reply   <= 2'd0;
          r_inh_cnt <= '0;
          if (int'(r_retry) + 1 < MAX_RETRY) begin
            r_retry   <= r_retry + 1'b1;
            r_clk_low <= 1'b1;
            r_state   <= S_INHIBIT;
          end else begin
            r_retry   <= r_retry + 1'b1;
            r_clk_low <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DEAD;
          end
        end

        S_DEAD: begin
          r_clk_low <= 1'b0;
          r_dat_low <= 1'b0;
          r_err     <= 1'b1;
        end

        default: begin
          r_clk_low <= 1'b1;
          r_state   <= S_INHIBIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
